// File: rtl/mem_port_arbiter_if.sv
// Bundles the two master ports and the memory port of mem_port_arbiter.
// slave = arbiter view; master = view of the CPU/RAM environment driving it.
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one single-port sync RAM (m0 = fetch, m1 = load/store); MEM_ARB_RR_EN selects round-robin ties.
// Latency: req in IDLE at cycle N -> ack at N+WAIT_STATES+2; one access per WAIT_STATES+3 cycles.
// Backpressure: requesters hold req/fields until their one-cycle ack; the loser of a tie simply waits.
module mem_port_arbiter #(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;       // 0 = m0, 1 = m1
    logic [3:0]    wait_q, wait_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          grant_m1;
    logic          in_access;
    logic          in_done;

`ifdef MEM_ARB_RR_EN
    logic          last_grant_q, last_grant_d;

    // On a tie the master that did not win last time takes the grant.
    assign grant_m1 = bus.m1_req & (~bus.m0_req | ~last_grant_q);
`else
    assign grant_m1 = bus.m1_req;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wait_d     = wait_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.m0_req | bus.m1_req) begin
                    owner_d = grant_m1;
                    wait_d  = WAIT_INIT;
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = grant_m1;
`endif
                end
            end
            ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!owner_q) begin
                    m0_rdata_d = bus.mem_rdata;
                end else if (!bus.m1_we) begin
                    m1_rdata_d = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            wait_q     <= 4'd0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_q     <= wait_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access & owner_q & bus.m1_we;
    assign bus.mem_addr  = in_access ? (owner_q ? bus.m1_addr : bus.m0_addr) : '0;
    assign bus.mem_wdata = (in_access & owner_q) ? bus.m1_wdata : '0;

    assign bus.m0_ack = in_done & ~owner_q;
    assign bus.m1_ack = in_done & owner_q;

    // RAM data only arrives in DONE, so it is passed straight through during
    // the ack cycle; the registers keep it visible afterwards.
    assign bus.m0_rdata = bus.m0_ack ? bus.mem_rdata : m0_rdata_q;
    assign bus.m1_rdata = (bus.m1_ack & ~bus.m1_we) ? bus.mem_rdata : m1_rdata_q;

    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a WAIT_STATES=1 instance with a RAM model, plus a WAIT_STATES=0 instance.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] mem [0:1023];

    mem_port_arbiter_if #(.AW(10), .DW(32)) bif ();
    mem_port_arbiter_if #(.AW(10), .DW(32)) bif0 ();

    mem_port_arbiter #(.AW(10), .DW(32), .WAIT_STATES(1)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bif.slave)
    );

    mem_port_arbiter #(.AW(10), .DW(32), .WAIT_STATES(0)) dut0 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bif0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (bif.mem_en) begin
            if (bif.mem_we) mem[bif.mem_addr] = bif.mem_wdata;
            else            bif.mem_rdata <= mem[bif.mem_addr];
        end
        if (bif0.mem_en && !bif0.mem_we) bif0.mem_rdata <= mem[bif0.mem_addr];
    end

    task automatic do_access(input logic sel, input logic we, input logic [9:0] addr,
                             input logic [31:0] wd, output int ack_cyc, output int en_cnt,
                             output logic [31:0] rd, output int bad_cyc);
        ack_cyc = -1; en_cnt = 0; bad_cyc = 0; rd = '0;
        @(negedge clk);
        if (sel) begin
            bif.m1_req = 1'b1; bif.m1_we = we; bif.m1_addr = addr; bif.m1_wdata = wd;
        end else begin
            bif.m0_req = 1'b1; bif.m0_addr = addr;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bif.mem_en === 1'b1) begin
                en_cnt++;
                if (bif.mem_addr !== addr || bif.mem_we !== (sel & we) ||
                    bif.mem_wdata !== (sel ? wd : 32'h0)) bad_cyc++;
            end else if (bif.mem_we !== 1'b0 || bif.mem_addr !== 10'h0 || bif.mem_wdata !== 32'h0) begin
                bad_cyc++;
            end
            if ((sel ? bif.m0_ack : bif.m1_ack) !== 1'b0) bad_cyc++;
            if ((sel ? bif.m1_ack : bif.m0_ack) === 1'b1) begin
                if (ack_cyc >= 0) bad_cyc++;
                else begin
                    ack_cyc = c;
                    rd = sel ? bif.m1_rdata : bif.m0_rdata;
                    bif.m0_req = 1'b0; bif.m1_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({bif.busy, bif.mem_en, bif.mem_we, bif.m0_ack, bif.m1_ack} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {bif.busy, bif.mem_en, bif.mem_we, bif.m0_ack, bif.m1_ack}); end
        total++; if (bif.mem_addr !== 10'h0 || bif.mem_wdata !== 32'h0) begin
            bad++; $display("FAIL reset_bus: addr=%h wdata=%h want 0", bif.mem_addr, bif.mem_wdata); end
        total++; if (bif.m0_rdata !== 32'h0 || bif.m1_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: m0=%h m1=%h want 0", bif.m0_rdata, bif.m1_rdata); end
        total++; if (bif0.busy !== 1'b0 || bif0.mem_en !== 1'b0) begin
            bad++; $display("FAIL reset_ws0: busy=%b en=%b want 0", bif0.busy, bif0.mem_en); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        bif.m1_req = 1'b1; bif.m1_we = 1'b1; bif.m1_addr = 10'h055; bif.m1_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        total++; if (bif.mem_en !== 1'b1 || bif.mem_we !== 1'b1) begin
            bad++; $display("FAIL midrst_access: en=%b we=%b want 1 1", bif.mem_en, bif.mem_we); end
        rst = 1'b1; bif.m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({bif.mem_en, bif.mem_we, bif.busy, bif.m1_ack, bif.m0_ack} !== 5'b0) begin
                bad++; $display("FAIL midrst_ctrl[%0d]: got %b want 00000", i,
                                {bif.mem_en, bif.mem_we, bif.busy, bif.m1_ack, bif.m0_ack}); end
            total++; if (bif.mem_addr !== 10'h0 || bif.mem_wdata !== 32'h0 || bif.m1_rdata !== 32'h0) begin
                bad++; $display("FAIL midrst_bus[%0d]: addr=%h wdata=%h rdata=%h want 0", i,
                                bif.mem_addr, bif.mem_wdata, bif.m1_rdata); end
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bif.busy !== 1'b0 || bif.m1_ack !== 1'b0) begin
            bad++; $display("FAIL midrst_after: busy=%b ack=%b want 0 0", bif.busy, bif.m1_ack); end
    endtask

    task automatic test_m0_read;
        int ac, ec, bc; logic [31:0] rd;
        do_access(1'b0, 1'b0, 10'h010, 32'h0, ac, ec, rd, bc);
        total++; if (ac !== 3) begin bad++; $display("FAIL m0_ack_cycle: got %0d want 3", ac); end
        total++; if (ec !== 2) begin bad++; $display("FAIL m0_en_cycles: got %0d want 2", ec); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL m0_rdata: got %h want deadbeef", rd); end
        total++; if (bc !== 0) begin bad++; $display("FAIL m0_bus: got %0d bad cycles want 0", bc); end
        total++; if (bif.m0_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL m0_rdata_hold: got %h want deadbeef", bif.m0_rdata); end
    endtask

    task automatic test_m1_write_readback;
        int ac, ec, bc; logic [31:0] rd;
        do_access(1'b1, 1'b1, 10'h3FF, 32'h12345678, ac, ec, rd, bc);
        total++; if (ac !== 3) begin bad++; $display("FAIL wr_ack_cycle: got %0d want 3", ac); end
        total++; if (ec !== 2) begin bad++; $display("FAIL wr_en_cycles: got %0d want 2", ec); end
        total++; if (bc !== 0) begin bad++; $display("FAIL wr_bus: got %0d bad cycles want 0", bc); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata_untouched: got %h want 0", rd); end
        do_access(1'b1, 1'b0, 10'h3FF, 32'h0, ac, ec, rd, bc);
        total++; if (ac !== 3) begin bad++; $display("FAIL rd_ack_cycle: got %0d want 3", ac); end
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL readback: got %h want 12345678", rd); end
        total++; if (bc !== 0) begin bad++; $display("FAIL rd_bus: got %0d bad cycles want 0", bc); end
    endtask

    task automatic test_arbitration;
        int k, last_c;
        logic exp_m1;
        k = 0; last_c = -1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bif.m0_req = 1'b1; bif.m0_addr = 10'h010;
        bif.m1_req = 1'b1; bif.m1_we = 1'b0; bif.m1_addr = 10'h3FF;
        for (int c = 1; c <= 60 && k < 8; c++) begin
            @(negedge clk);
            if (bif.m0_ack === 1'b1 && bif.m1_ack === 1'b1) begin
                total++; bad++; $display("FAIL arb_double_ack: cycle %0d both acks high", c);
            end
            if (bif.m0_ack === 1'b1 || bif.m1_ack === 1'b1) begin
`ifdef MEM_ARB_RR_EN
                exp_m1 = (k % 2) == 1;
`else
                exp_m1 = 1'b1;
`endif
                total++; if (bif.m1_ack !== exp_m1) begin
                    bad++; $display("FAIL arb_grant[%0d]: got m1_ack=%b want %b", k, bif.m1_ack, exp_m1); end
                if (last_c >= 0) begin
                    total++; if (c - last_c !== 4) begin
                        bad++; $display("FAIL arb_spacing[%0d]: got %0d want 4", k, c - last_c); end
                end
                last_c = c; k++;
                if (k == 8) begin bif.m0_req = 1'b0; bif.m1_req = 1'b0; end
            end
        end
        total++; if (k !== 8) begin bad++; $display("FAIL arb_count: got %0d acks want 8", k); end
        bif.m0_req = 1'b0; bif.m1_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_done_handoff;
        logic [12:0] en_hist;
        int a0, a1;
        logic [31:0] rd1;
        en_hist = '0; a0 = -1; a1 = -1; rd1 = '0;
        bif.m0_req = 1'b1; bif.m0_addr = 10'h010;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            en_hist[c] = bif.mem_en;
            if (bif.m1_ack === 1'b1) begin a1 = c; rd1 = bif.m1_rdata; bif.m1_req = 1'b0; end
            if (bif.m0_ack === 1'b1) begin
                a0 = c; bif.m0_req = 1'b0;
                bif.m1_req = 1'b1; bif.m1_we = 1'b0; bif.m1_addr = 10'h3FF;
            end
        end
        total++; if (a0 !== 3) begin bad++; $display("FAIL handoff_m0_ack: got %0d want 3", a0); end
        total++; if (a1 !== 7) begin bad++; $display("FAIL handoff_m1_ack: got %0d want 7", a1); end
        total++; if (en_hist !== 13'h0066) begin bad++; $display("FAIL handoff_en: got %h want 0066", en_hist); end
        total++; if (rd1 !== 32'h12345678) begin bad++; $display("FAIL handoff_rdata: got %h want 12345678", rd1); end
    endtask

    task automatic test_ws0;
        int ac, ec, k, last_c;
        logic [31:0] rd;
        ac = -1; ec = 0; rd = '0;
        @(negedge clk);
        bif0.m0_req = 1'b1; bif0.m0_addr = 10'h010;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bif0.mem_en === 1'b1) ec++;
            if (bif0.m0_ack === 1'b1 && ac < 0) begin ac = c; rd = bif0.m0_rdata; bif0.m0_req = 1'b0; end
        end
        total++; if (ac !== 2) begin bad++; $display("FAIL ws0_ack_cycle: got %0d want 2", ac); end
        total++; if (ec !== 1) begin bad++; $display("FAIL ws0_en_cycles: got %0d want 1", ec); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ws0_rdata: got %h want deadbeef", rd); end
        k = 0; last_c = -1;
        bif0.m0_req = 1'b1; bif0.m0_addr = 10'h020;
        for (int c = 1; c <= 30 && k < 3; c++) begin
            @(negedge clk);
            if (bif0.m0_ack === 1'b1) begin
                total++; if (bif0.m0_rdata !== 32'hC0DE0020) begin
                    bad++; $display("FAIL ws0_b2b_rdata[%0d]: got %h want c0de0020", k, bif0.m0_rdata); end
                if (last_c >= 0) begin
                    total++; if (c - last_c !== 3) begin
                        bad++; $display("FAIL ws0_b2b_spacing[%0d]: got %0d want 3", k, c - last_c); end
                end
                last_c = c; k++;
                if (k == 3) bif0.m0_req = 1'b0;
            end
        end
        total++; if (k !== 3) begin bad++; $display("FAIL ws0_b2b_count: got %0d want 3", k); end
        bif0.m0_req = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
        mem[10'h010] = 32'hDEADBEEF;
        bif.m0_req = 1'b0; bif.m0_addr = '0;
        bif.m1_req = 1'b0; bif.m1_we = 1'b0; bif.m1_addr = '0; bif.m1_wdata = '0;
        bif0.m0_req = 1'b0; bif0.m0_addr = '0;
        bif0.m1_req = 1'b0; bif0.m1_we = 1'b0; bif0.m1_addr = '0; bif0.m1_wdata = '0;
        rst = 1'b1;
        test_reset();
        test_reset_mid_write();
        test_m0_read();
        test_m1_write_readback();
        test_arbitration();
        test_done_handoff();
        test_ws0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
